// File: rtl/serial_add_pkg.sv
// Shared types and default sizing for the bit-serial adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sa_state_e;

    localparam int unsigned SA_N      = 8;
    localparam int unsigned SA_FA_LAT = 6;

endpackage

// File: rtl/slot_timer.sv
// Wait counter for perceptron-pipeline sequencers: counts while enabled and
// pulses tc_c on the last cycle of each LAT-cycle slot, then restarts at 0.
module slot_timer #(
    parameter int unsigned LAT = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    output logic [$clog2(LAT+1)-1:0]   cnt,
    output logic                       tc_c
);

    localparam int unsigned CW = $clog2(LAT + 1);

    assign tc_c = en && (cnt == CW'(LAT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tc_c) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer driving a clocked full_adder, LSB first.
// Optional SERIAL_ADD_OVF_EN adds a signed-overflow output.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned N      = SA_N,
    parameter int unsigned FA_LAT = SA_FA_LAT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         fa_a,
    output logic         fa_b,
    output logic         fa_cin,
    input  logic         fa_sum,
    input  logic         fa_cout,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef SERIAL_ADD_OVF_EN
    output logic         ovf,
`endif
    output logic [N-1:0] sum,
    output logic         c_out
);

    localparam int unsigned BW = $clog2(N);
    localparam int unsigned CW = $clog2(FA_LAT + 1);

    sa_state_e       state;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [N-1:0]    sum_reg;
    logic [N-1:0]    sum_upd;
    logic            carry;
    logic [BW-1:0]   bit_idx;
    logic [BW-1:0]   bit_nxt;
    logic [CW-1:0]   cnt;
    logic            slot_done;
    logic            last_bit;

    slot_timer #(.LAT(FA_LAT)) u_slot_timer (
        .clk   (clk),
        .reset (reset),
        .en    (state == DRIVE),
        .cnt   (cnt),
        .tc_c  (slot_done)
    );

    assign bit_nxt  = bit_idx + BW'(1);
    assign last_bit = (bit_idx == BW'(N - 1));

    // Result register with the bit currently being sampled merged in.
    always_comb begin
        sum_upd          = sum_reg;
        sum_upd[bit_idx] = fa_sum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry     <= 1'b0;
            bit_idx   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            fa_a      <= 1'b0;
            fa_b      <= 1'b0;
            fa_cin    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= c_in;
                        sum_reg  <= '0;
                        bit_idx  <= '0;
                        fa_a     <= a[0];
                        fa_b     <= b[0];
                        fa_cin   <= c_in;
                        in_ready <= 1'b0;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (slot_done) begin
                        sum_reg <= sum_upd;
                        carry   <= fa_cout;
                        if (last_bit) begin
                            sum       <= sum_upd;
                            c_out     <= fa_cout;
                            out_valid <= 1'b1;
                            fa_a      <= 1'b0;
                            fa_b      <= 1'b0;
                            fa_cin    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                            ovf       <= carry ^ fa_cout;
`endif
                            state     <= DONE;
                        end else begin
                            // Next bit pair goes out with the fresh carry recirculated.
                            bit_idx <= bit_nxt;
                            fa_a    <= a_reg[bit_nxt];
                            fa_b    <= b_reg[bit_nxt];
                            fa_cin  <= fa_cout;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural pipelined full adder.
module tb_serial_add_ctrl;

    localparam int N      = 8;
    localparam int FA_LAT = 6;
    localparam int PD     = FA_LAT - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.N(N), .FA_LAT(FA_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SERIAL_ADD_OVF_EN
        .ovf       (ovf),
`endif
        .sum       (sum),
        .c_out     (c_out)
    );

    // Full adder stand-in: PD register stages, reset through reset_n.
    logic       reset_n;
    logic [1:0] fa_pipe [PD];
    assign reset_n = ~reset;
    assign fa_sum  = fa_pipe[PD-1][0];
    assign fa_cout = fa_pipe[PD-1][1];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PD; i++) fa_pipe[i] <= 2'b00;
        end else begin
            fa_pipe[0] <= {(fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin),
                           fa_a ^ fa_b ^ fa_cin};
            for (int i = 1; i < PD; i++) fa_pipe[i] <= fa_pipe[i-1];
        end
    end

    // Issue one operand set and wait (bounded) for out_valid; no checking here.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          input logic tc, output int lat, output logic ir_seen);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        ir_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ir_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b sum=%h c_out=%b want 1 0 00 0",
                     in_ready, out_valid, sum, c_out);
        end
        total++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            bad++;
            $display("FAIL reset_fa: got %b want 000", {fa_a, fa_b, fa_cin});
        end
    endtask

    task automatic test_basic();
        int lat; logic irs;
        run_op(8'h35, 8'h4A, 1'b0, lat, irs);
        total++;
        if (lat !== 48) begin bad++; $display("FAIL basic_latency: got %0d want 48", lat); end
        total++;
        if (sum !== 8'h7F || c_out !== 1'b0) begin
            bad++; $display("FAIL basic_sum: got %h/%b want 7f/0", sum, c_out);
        end
        total++;
        if (irs !== 1'b0) begin bad++; $display("FAIL basic_in_ready: got %b want 0", irs); end
        total++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            bad++; $display("FAIL done_fa: got %b want 000", {fa_a, fa_b, fa_cin});
        end
        pop();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_carry();
        int lat; logic irs;
        run_op(8'hFF, 8'h01, 1'b0, lat, irs);
        total++;
        if (sum !== 8'h00 || c_out !== 1'b1) begin
            bad++; $display("FAIL carry_ff_01: got %h/%b want 00/1", sum, c_out);
        end
        pop();
        run_op(8'hFF, 8'h00, 1'b1, lat, irs);
        total++;
        if (sum !== 8'h00 || c_out !== 1'b1 || lat !== 48) begin
            bad++; $display("FAIL carry_ripple: got %h/%b lat=%0d want 00/1 lat=48", sum, c_out, lat);
        end
        pop();
    endtask

    task automatic test_backpressure();
        int lat; logic irs;
        run_op(8'h12, 8'h34, 1'b0, lat, irs);
        for (int i = 0; i < 10; i++) begin
            a = 8'hAB; b = 8'hCD; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || sum !== 8'h46 || c_out !== 1'b0 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: ov=%b sum=%h c=%b ir=%b want 1 46 0 0",
                         i, out_valid, sum, c_out, in_ready);
            end
        end
        in_valid = 1'b0;
        pop();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h46) begin
            bad++; $display("FAIL bp_release: ir=%b ov=%b sum=%h want 1 0 46", in_ready, out_valid, sum);
        end
        run_op(8'h10, 8'h20, 1'b0, lat, irs);
        total++;
        if (sum !== 8'h30 || c_out !== 1'b0 || lat !== 48) begin
            bad++; $display("FAIL bp_next: got %h/%b lat=%0d want 30/0 lat=48", sum, c_out, lat);
        end
        pop();
    endtask

    task automatic test_mid_reset();
        int lat; logic irs;
        a = 8'hAA; b = 8'h55; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
        total++;
        if (fa_a !== 1'b1 || fa_b !== 1'b0 || fa_cin !== 1'b0) begin
            bad++; $display("FAIL bit3_drive: got %b%b%b want 100", fa_a, fa_b, fa_cin);
        end
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || sum !== 8'h00 || c_out !== 1'b0 || {fa_a, fa_b, fa_cin} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset: ov=%b sum=%h c=%b fa=%b%b%b want 0 00 0 000",
                     out_valid, sum, c_out, fa_a, fa_b, fa_cin);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
        run_op(8'h01, 8'h01, 1'b0, lat, irs);
        total++;
        if (sum !== 8'h02 || c_out !== 1'b0 || lat !== 48) begin
            bad++; $display("FAIL post_reset_op: got %h/%b lat=%0d want 02/0 lat=48", sum, c_out, lat);
        end
        pop();
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        int lat; logic irs;
        run_op(8'h7F, 8'h01, 1'b0, lat, irs);
        total++;
        if (sum !== 8'h80 || c_out !== 1'b0 || ovf !== 1'b1) begin
            bad++; $display("FAIL ovf_7f_01: got %h/%b/%b want 80/0/1", sum, c_out, ovf);
        end
        pop();
        run_op(8'h80, 8'h80, 1'b0, lat, irs);
        total++;
        if (sum !== 8'h00 || c_out !== 1'b1 || ovf !== 1'b1) begin
            bad++; $display("FAIL ovf_80_80: got %h/%b/%b want 00/1/1", sum, c_out, ovf);
        end
        pop();
        run_op(8'hFF, 8'h01, 1'b0, lat, irs);
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_ff_01: got %b want 0", ovf); end
        pop();
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_mid_reset();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial sequencer wrapped around the clocked, perceptron-built full_adder. It accepts two N-bit operands plus carry-in over a valid/ready handshake. It feeds the adder one bit pair per slot, LSB first, holding the inputs for FA_LAT cycles until the adder's registered outputs settle. It collects sum bits into a result register and recirculates carry-out into the next bit's carry-in. The block is both the upstream driver and the downstream consumer of the full_adder.

Parameters:
N, 8, operand/result width; must be >= 2.
FA_LAT, 6, cycles a bit pair is held before fa_sum/fa_cout are sampled; must be >= 1. 6 is the sum-path perceptron depth of full_adder.

Ports:
clk  in  1  clock, shared with full_adder
reset  in  1  asynchronous active-high reset; the full_adder instance receives reset_n = ~reset at the parent
in_valid  in  1  operand valid
in_ready  out  1  block can accept operands
a  in  N  operand A
b  in  N  operand B
c_in  in  1  initial carry
fa_a  out  1  bit to full_adder A
fa_b  out  1  bit to full_adder B
fa_cin  out  1  carry to full_adder C_in
fa_sum  in  1  full_adder sum
fa_cout  in  1  full_adder C_out
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  N  result
c_out  out  1  final carry

Behaviour:
- States: IDLE, DRIVE, DONE.
- Reset (async, any state): state=IDLE; a_reg, b_reg, sum_reg, carry, bit index, and wait counter all 0. Outputs: in_ready=1, out_valid=0, sum=0, c_out=0, fa_a/fa_b/fa_cin=0.
- in_ready = (state==IDLE).
- IDLE:
  - on in_valid && in_ready at an edge: latch a, b, and c_in into carry; clear sum_reg; bit=0, cnt=0; go to DRIVE.
  - in_valid while not IDLE is ignored; no accept.
- DRIVE:
  - fa_a=a_reg[bit], fa_b=b_reg[bit], fa_cin=carry, held constant for FA_LAT cycles.
  - cnt increments every cycle.
  - When cnt==FA_LAT-1, at that edge: sum_reg[bit]<=fa_sum, carry<=fa_cout, cnt<=0.
  - If bit==N-1, go to DONE; else bit<=bit+1.
- Latency: out_valid rises exactly N*FA_LAT cycles after the accepting edge (48 at defaults).
- DONE:
  - out_valid=1, sum=sum_reg, c_out=carry, all stable while out_ready=0.
  - fa_* driven 0.
  - On out_valid && out_ready: go to IDLE. in_ready rises the next cycle; no same-cycle re-accept.
- Outside DONE: sum and c_out hold their last values (0 after reset); consumers qualify them with out_valid only.
- Widths: bit index is clog2(N) bits; cnt is clog2(FA_LAT+1) bits; neither wraps mid-operation.
- Reset asserted mid-DRIVE discards the operation. The full_adder pipeline is reset simultaneously through reset_n, so no stale bits survive.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined: adds output port ovf (1 bit) = signed overflow.
  - On the final sample edge, ovf_reg <= carry_before_msb XOR fa_cout, where carry_before_msb is the carry driven on fa_cin for bit N-1.
  - Valid with out_valid; reset 0.
- Undefined: no ovf port and no extra register.

Decomposition:
- Package serial_add_pkg:
  - state enum (IDLE=2'd0, DRIVE=2'd1, DONE=2'd2)
  - default constants SA_N=8 and SA_FA_LAT=6
- One natural sub-module: slot_timer, the FA_LAT wait counter with a terminal-count pulse output, reusable for other perceptron-pipeline sequencers.
- Datapath and FSM stay in serial_add_ctrl.

Test Plan:
- Bench: N=8, FA_LAT=6, real full_adder instance (reset_n=~reset).
- a=8'h35, b=8'h4A, c_in=0 -> sum=8'h7F, c_out=0; out_valid exactly 48 cycles after the accept edge; in_ready=0 throughout.
- a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1. Separately, a=8'hFF, b=8'h00, c_in=1 -> sum=8'h00, c_out=1 (carry ripples all 8 bits).
- Backpressure: a=8'h12, b=8'h34; hold out_ready=0 for 10 cycles after out_valid -> sum=8'h46 and out_valid stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> IDLE, in_ready=1 next cycle, next operands accepted.
- Reset mid-operation: assert reset during bit 3 of a=8'hAA+b=8'h55 -> all outputs 0 immediately, in_ready=1 after release. A following 8'h01+8'h01 yields 8'h02, c_out=0.
- SERIAL_ADD_OVF_EN defined:
  - 8'h7F+8'h01 -> sum=8'h80, c_out=0, ovf=1
  - 8'h80+8'h80 -> sum=8'h00, c_out=1, ovf=1
  - 8'hFF+8'h01 -> ovf=0
